// File: rtl/fetch_unit_if.sv
// Instruction-memory port between the fetch unit (master) and a combinational imem (slave).
// Latency: none, imem_q answers imem_addr within the same cycle.
// Backpressure: none, the imem always answers.
interface fetch_unit_if #(
   parameter int IMEM_AW = 6
);
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_q;

   modport master (output imem_addr, input imem_q);
   modport slave  (input imem_addr, output imem_q);
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 fetch front end: owns the PC, reads imem, loads IF/ID, detects halt and PC faults.
// Latency: the instruction addressed by PC appears in IF/ID one edge later.
// Backpressure: stall_i holds PC and IF/ID. Optional counters behind FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter int          N          = 64,
   parameter int          IMEM_AW    = 6,
   parameter logic [31:0] HALT_INSTR = 32'hb400001f
) (
   input  logic          clk,
   input  logic          reset,
   fetch_unit_if.master  imem,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          branch_taken_i,
   input  logic [N-1:0]  branch_target_i,
   output logic [N-1:0]  if_id_pc,
   output logic [31:0]   if_id_instr,
   output logic          if_id_valid,
   output logic          halted,
   output logic          pc_fault
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]   fetch_count,
   output logic [31:0]   stall_count
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [N-1:0] PC_STEP = N'(4);

   state_t        state_q;
   logic [N-1:0]  pc_q;
   logic [N-1:0]  if_id_pc_q;
   logic [31:0]   if_id_instr_q;
   logic          if_id_valid_q;
   logic          halted_q;
   logic          pc_fault_q;

   logic [N-1:0]  pc_inc_d;
   logic          tgt_bad_d;
   logic          inc_bad_d;
   logic          is_halt_d;

   // A byte address is unusable if misaligned or beyond the last imem word.
   function automatic logic addr_bad(input logic [N-1:0] a);
      return (a[1:0] != 2'b00) || (a[N-1:IMEM_AW+2] != '0);
   endfunction

   // Sequential successor and the range checks on both candidate next PCs.
   always_comb begin
      pc_inc_d  = pc_q + PC_STEP;
      tgt_bad_d = addr_bad(branch_target_i);
      inc_bad_d = addr_bad(pc_inc_d);
      is_halt_d = (imem.imem_q == HALT_INSTR);
   end

   assign imem.imem_addr = pc_q[IMEM_AW+1:2];
   assign if_id_pc       = if_id_pc_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_valid    = if_id_valid_q;
   assign halted         = halted_q;
   assign pc_fault       = pc_fault_q;

   // Fetch FSM: PC, IF/ID register and status flags, all updated together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         pc_q          <= '0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= '0;
         if_id_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         pc_fault_q    <= 1'b0;
      end else begin
         case (state_q)
            RUN, HALT: begin
               if (branch_taken_i) begin
                  // Redirect squashes the slot in flight; a bad target freezes PC.
                  if_id_valid_q <= 1'b0;
                  if_id_instr_q <= '0;
                  halted_q      <= 1'b0;
                  if (tgt_bad_d) begin
                     state_q    <= FAULT;
                     pc_fault_q <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     pc_q    <= branch_target_i;
                  end
               end else if (state_q == HALT) begin
                  if_id_valid_q <= 1'b0;
                  if_id_instr_q <= '0;
               end else if (flush_i) begin
                  if_id_valid_q <= 1'b0;
                  if_id_instr_q <= '0;
                  if (inc_bad_d) begin
                     state_q    <= FAULT;
                     pc_fault_q <= 1'b1;
                  end else begin
                     pc_q <= pc_inc_d;
                  end
               end else if (!stall_i) begin
                  // Normal fetch; the halt word itself is delivered valid.
                  if_id_pc_q    <= pc_q;
                  if_id_instr_q <= imem.imem_q;
                  if_id_valid_q <= 1'b1;
                  if (is_halt_d) begin
                     state_q  <= HALT;
                     halted_q <= 1'b1;
                  end else if (inc_bad_d) begin
                     state_q    <= FAULT;
                     pc_fault_q <= 1'b1;
                  end else begin
                     pc_q <= pc_inc_d;
                  end
               end
            end
            default: begin
               // FAULT: frozen until reset, only bubbles leave IF/ID.
               if_id_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q;
   logic [31:0] stall_count_q;
   logic        run_d;

   assign run_d       = (state_q == RUN);
   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;

   // Event counters; both naturally freeze outside RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         if (run_d && !branch_taken_i && !flush_i && !stall_i) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         if (run_d && stall_i && !branch_taken_i) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-edge vectors plus hand sequences.
// Latency: checks IF/ID 1 time unit after each rising edge.
// Backpressure: stall, flush and branch are driven from the vector rows.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i, flush_i, branch_taken_i;
   logic [63:0] branch_target_i;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid, halted, pc_fault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count;
`endif

   logic [31:0] mem [64];

   fetch_unit_if #(.IMEM_AW(6)) imem_bus ();
   assign imem_bus.imem_q = mem[imem_bus.imem_addr];

   fetch_unit #(.N(64), .IMEM_AW(6), .HALT_INSTR(32'hb400001f)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem            (imem_bus),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .if_id_pc        (if_id_pc),
      .if_id_instr     (if_id_instr),
      .if_id_valid     (if_id_valid),
      .halted          (halted),
      .pc_fault        (pc_fault)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count     (fetch_count),
      .stall_count     (stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, stall, flush, br;
      logic [63:0] tgt;
      logic [63:0] e_pc;
      logic [31:0] e_instr;
      logic        e_vld, e_halt, e_fault;
      logic [5:0]  e_addr;
   } vec_t;

   vec_t tv[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic rst, stall, flush, br, input logic [63:0] tgt,
                               input logic [63:0] pc, input logic [31:0] instr,
                               input logic vld, hlt, flt, input logic [5:0] addr);
      vec_t v;
      v.rst = rst; v.stall = stall; v.flush = flush; v.br = br; v.tgt = tgt;
      v.e_pc = pc; v.e_instr = instr; v.e_vld = vld; v.e_halt = hlt;
      v.e_fault = flt; v.e_addr = addr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, stall, flush, br, input logic [63:0] tgt);
      reset = rst; stall_i = stall; flush_i = flush;
      branch_taken_i = br; branch_target_i = tgt;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h8b000000 + i;
      mem[0]  = 32'hf8000001;
      mem[1]  = 32'hf8008002;
      mem[2]  = 32'hf8000203;
      mem[4]  = 32'hf8018003;
      mem[5]  = 32'hcb050083;
      mem[29] = 32'hb4000040;
      mem[46] = 32'hb400001f;

      //          rst stl fls br  tgt      pc       instr          v  h  f  addr
      tv.push_back(mk(1, 0, 0, 0, 64'h0,   64'h0,   32'h0,         0, 0, 0, 6'd0));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h0,   32'hf8000001,  1, 0, 0, 6'd1));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h4,   32'hf8008002,  1, 0, 0, 6'd2));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h8,   32'hf8000203,  1, 0, 0, 6'd3));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'hc,   32'h8b000003,  1, 0, 0, 6'd4));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h10,  32'hf8018003,  1, 0, 0, 6'd5));
      for (int k = 0; k < 3; k++)
         tv.push_back(mk(0, 1, 0, 0, 64'h0, 64'h10, 32'hf8018003,  1, 0, 0, 6'd5));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h14,  32'hcb050083,  1, 0, 0, 6'd6));
      // branch overrides stall
      tv.push_back(mk(0, 1, 0, 1, 64'h74,  64'h14,  32'h0,         0, 0, 0, 6'd29));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h74,  32'hb4000040,  1, 0, 0, 6'd30));
      // flush discards the slot but PC advances
      tv.push_back(mk(0, 0, 1, 0, 64'h0,   64'h74,  32'h0,         0, 0, 0, 6'd31));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h7c,  32'h8b00001f,  1, 0, 0, 6'd32));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h80,  32'h8b000020,  1, 0, 0, 6'd33));
      tv.push_back(mk(0, 0, 1, 1, 64'hb0,  64'h80,  32'h0,         0, 0, 0, 6'd44));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'hb0,  32'h8b00002c,  1, 0, 0, 6'd45));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'hb4,  32'h8b00002d,  1, 0, 0, 6'd46));
      // halt word latched valid, PC holds
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'hb8,  32'hb400001f,  1, 1, 0, 6'd46));
      for (int k = 0; k < 6; k++)
         tv.push_back(mk(0, k[0], k[1], 0, 64'h0, 64'hb8, 32'h0,   0, 1, 0, 6'd46));
      tv.push_back(mk(0, 1, 0, 1, 64'h0,   64'hb8,  32'h0,         0, 0, 0, 6'd0));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h0,   32'hf8000001,  1, 0, 0, 6'd1));
      // misaligned target faults, then everything but reset is ignored
      tv.push_back(mk(0, 0, 0, 1, 64'h102, 64'h0,   32'h0,         0, 0, 1, 6'd1));
      tv.push_back(mk(0, 0, 0, 1, 64'h10,  64'h0,   32'h0,         0, 0, 1, 6'd1));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h0,   32'h0,         0, 0, 1, 6'd1));
      tv.push_back(mk(1, 0, 0, 0, 64'h0,   64'h0,   32'h0,         0, 0, 0, 6'd0));
      // first out-of-range byte address
      tv.push_back(mk(0, 0, 0, 1, 64'h100, 64'h0,   32'h0,         0, 0, 1, 6'd0));
      tv.push_back(mk(1, 0, 0, 0, 64'h0,   64'h0,   32'h0,         0, 0, 0, 6'd0));
      tv.push_back(mk(0, 0, 0, 0, 64'h0,   64'h0,   32'hf8000001,  1, 0, 0, 6'd1));

      drive(1, 0, 0, 0, 64'h0);
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].rst, tv[i].stall, tv[i].flush, tv[i].br, tv[i].tgt);
         edge_step();
         chk($sformatf("row%0d.pc", i),    if_id_pc,                    tv[i].e_pc);
         chk($sformatf("row%0d.instr", i), {32'h0, if_id_instr},        {32'h0, tv[i].e_instr});
         chk($sformatf("row%0d.valid", i), {63'h0, if_id_valid},        {63'h0, tv[i].e_vld});
         chk($sformatf("row%0d.halted", i),{63'h0, halted},             {63'h0, tv[i].e_halt});
         chk($sformatf("row%0d.fault", i), {63'h0, pc_fault},           {63'h0, tv[i].e_fault});
         chk($sformatf("row%0d.addr", i),  {58'h0, imem_bus.imem_addr}, {58'h0, tv[i].e_addr});
      end
`ifdef FETCH_PERF_CNT_EN
      chk("cnt.fetch_after_row", {32'h0, fetch_count}, 64'd1);
`endif

      // Sequential fetch off the end of imem: 0xFC delivered, then fault, no wrap.
      drive(0, 0, 0, 1, 64'hf8);
      edge_step();
      chk("seq.br_addr", {58'h0, imem_bus.imem_addr}, 64'd62);
      drive(0, 0, 0, 0, 64'h0);
      edge_step();
      chk("seq.pc_f8", if_id_pc, 64'hf8);
      chk("seq.instr_f8", {32'h0, if_id_instr}, 64'h8b00003e);
      edge_step();
      chk("seq.pc_fc", if_id_pc, 64'hfc);
      chk("seq.instr_fc", {32'h0, if_id_instr}, 64'h8b00003f);
      chk("seq.addr_fc", {58'h0, imem_bus.imem_addr}, 64'd63);
      edge_step();
      chk("seq.fault", {63'h0, pc_fault}, 64'd1);
      chk("seq.fault_valid", {63'h0, if_id_valid}, 64'd0);
      chk("seq.fault_addr", {58'h0, imem_bus.imem_addr}, 64'd63);

      // Reset mid-run wins over a simultaneous branch.
      drive(1, 0, 0, 0, 64'h0);
      edge_step();
      drive(0, 0, 0, 0, 64'h0);
      for (int k = 0; k < 3; k++) edge_step();
      drive(0, 1, 0, 0, 64'h0);
      edge_step();
`ifdef FETCH_PERF_CNT_EN
      chk("cnt.fetch_run", {32'h0, fetch_count}, 64'd3);
      chk("cnt.stall_run", {32'h0, stall_count}, 64'd1);
`endif
      drive(1, 0, 0, 1, 64'h40);
      edge_step();
      chk("rst.pc", if_id_pc, 64'h0);
      chk("rst.instr", {32'h0, if_id_instr}, 64'h0);
      chk("rst.valid", {63'h0, if_id_valid}, 64'd0);
      chk("rst.halted", {63'h0, halted}, 64'd0);
      chk("rst.fault", {63'h0, pc_fault}, 64'd0);
      chk("rst.addr", {58'h0, imem_bus.imem_addr}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst.fetch_count", {32'h0, fetch_count}, 64'd0);
      chk("rst.stall_count", {32'h0, stall_count}, 64'd0);
`endif
      drive(0, 0, 0, 0, 64'h0);
      edge_step();
      chk("post_rst.instr", {32'h0, if_id_instr}, 64'hf8000001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
